// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one FIFO write port between N_REQ
//   requesters in the write clock domain. Each grant accepts a burst of up
//   to MAX_BURST beats. Beats are throttled while the FIFO is full. A clear
//   request stops granting, holds fifo_wclr for CLR_CYCLES cycles and then
//   pulses clr_done.
//
// Ports
//   clk         write-domain clock, rising edge
//   rst_n       asynchronous active-low reset
//   req         per-requester write request (level, held until accepted)
//   req_data    per-requester data, requester i at [i*DATA_W +: DATA_W]
//   gnt         one-hot accept; beat from requester i taken when gnt[i]=1
//   fifo_full   FIFO write-side full flag
//   fifo_winc   FIFO write increment
//   fifo_wdata  FIFO write data (owner's slice while granting, else 0)
//   fifo_wclr   FIFO write-side synchronous clear
//   clr_req     single-cycle clear request pulse
//   clr_busy    clear pending or in progress
//   clr_done    single-cycle pulse at the end of a clear
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = 8,
    parameter int MAX_BURST  = 4,
    parameter int CLR_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    input  logic                    fifo_full,
    output logic                    fifo_winc,
    output logic [DATA_W-1:0]       fifo_wdata,
    output logic                    fifo_wclr,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic                    clr_done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(N_REQ - 1);
    localparam logic [3:0]       BURST_LAST = 4'(MAX_BURST - 1);
    localparam logic [3:0]       CLR_LAST   = 4'(CLR_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last;
    logic [3:0]       beat_cnt;
    logic [3:0]       clr_cnt;
    logic             clr_pend;

    logic             accept;
    logic             found;
    logic [IDX_W-1:0] next_owner;
    logic [IDX_W-1:0] rr_idx;

    // Round-robin search starting just after the previous owner, wrapping.
    always_comb begin
        found      = 1'b0;
        next_owner = '0;
        rr_idx     = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            rr_idx = IDX_W'((32'(last) + i) % N_REQ);
            if (!found && req[rr_idx]) begin
                found      = 1'b1;
                next_owner = rr_idx;
            end
        end
    end

    // clr_pend blocks beats from the cycle after the clear request.
    assign accept = (state == S_GRANT) && req[owner] && !fifo_full && !clr_pend;

    always_comb begin
        gnt = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            gnt[i] = accept && (owner == IDX_W'(i));
        end
    end

    assign fifo_winc  = accept;
    assign fifo_wdata = (state == S_GRANT) ? req_data[int'(owner)*DATA_W +: DATA_W] : '0;
    assign fifo_wclr  = (state == S_CLEAR);
    assign clr_done   = (state == S_DONE);
    assign clr_busy   = clr_pend || (state == S_CLEAR) || (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            owner    <= '0;
            last     <= LAST_INIT;
            beat_cnt <= '0;
            clr_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clr_pend || clr_req) begin
                        state   <= S_CLEAR;
                        clr_cnt <= '0;
                    end else if (found) begin
                        owner    <= next_owner;
                        beat_cnt <= '0;
                        state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                    if ((accept && beat_cnt == BURST_LAST) || !req[owner] || clr_pend) begin
                        state <= S_IDLE;
                        last  <= owner;
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state   <= S_DONE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    last  <= LAST_INIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pending clear: dropped on entry to CLEAR, requests during CLEAR/DONE ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_pend <= 1'b0;
        end else if (state == S_IDLE && (clr_pend || clr_req)) begin
            clr_pend <= 1'b0;
        end else if (clr_req && state != S_CLEAR && state != S_DONE) begin
            clr_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter (N_REQ=4, DATA_W=8,
//   MAX_BURST=4, CLR_CYCLES=2). Inputs change just after the falling edge;
//   outputs are sampled 1 time unit later, well before the rising edge.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        fifo_full;
    logic        fifo_winc;
    logic [7:0]  fifo_wdata;
    logic        fifo_wclr;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ(4),
        .DATA_W(8),
        .MAX_BURST(4),
        .CLR_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .fifo_full(fifo_full),
        .fifo_winc(fifo_winc),
        .fifo_wdata(fifo_wdata),
        .fifo_wclr(fifo_wclr),
        .clr_req(clr_req),
        .clr_busy(clr_busy),
        .clr_done(clr_done)
    );

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic       clr;
        logic [3:0] gnt;
        logic       winc;
        logic [7:0] wdata;
        logic       wclr;
        logic       busy;
        logic       done;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] data;
    } beat_t;

    vec_t  vq[$];
    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [7:0] data_of(input int i);
        return 8'(8'h11 * (i + 1));
    endfunction

    function automatic void v(input logic [3:0] r, input logic f, input logic c,
                              input logic [3:0] g, input logic w, input logic [7:0] d,
                              input logic wc, input logic b, input logic dn);
        vec_t e;
        e.req = r; e.full = f; e.clr = c;
        e.gnt = g; e.winc = w; e.wdata = d; e.wclr = wc; e.busy = b; e.done = dn;
        vq.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            vec_t e;
            e         = vq[i];
            req       = e.req;
            fifo_full = e.full;
            clr_req   = e.clr;
            #1;
            chk($sformatf("%s[%0d].gnt", tag, i), 32'(gnt), 32'(e.gnt));
            chk($sformatf("%s[%0d].winc", tag, i), 32'(fifo_winc), 32'(e.winc));
            chk($sformatf("%s[%0d].wdata", tag, i), 32'(fifo_wdata), 32'(e.wdata));
            chk($sformatf("%s[%0d].wclr", tag, i), 32'(fifo_wclr), 32'(e.wclr));
            chk($sformatf("%s[%0d].busy", tag, i), 32'(clr_busy), 32'(e.busy));
            chk($sformatf("%s[%0d].done", tag, i), 32'(clr_done), 32'(e.done));
            chk($sformatf("%s[%0d].winc_wclr", tag, i), 32'(fifo_winc & fifo_wclr), 32'd0);
            @(negedge clk);
        end
        vq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        beat_t b;
        req_data  = {data_of(3), data_of(2), data_of(1), data_of(0)};
        rst_n     = 1'b0;
        req       = 4'b0001;
        fifo_full = 1'b0;
        clr_req   = 1'b0;

        // Reset: every output low even with a request present.
        repeat (3) @(negedge clk);
        #1;
        chk("reset.gnt", 32'(gnt), 32'd0);
        chk("reset.winc", 32'(fifo_winc), 32'd0);
        chk("reset.wdata", 32'(fifo_wdata), 32'd0);
        chk("reset.wclr", 32'(fifo_wclr), 32'd0);
        chk("reset.busy", 32'(clr_busy), 32'd0);
        chk("reset.done", 32'(clr_done), 32'd0);
        rst_n = 1'b1;

        // A: single requester, two full bursts separated by one bubble.
        v(4'b0001, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        for (int k = 0; k < 4; k++) v(4'b0001, 0, 0, 4'b0001, 1, 8'h11, 0, 0, 0);
        v(4'b0001, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        for (int k = 0; k < 4; k++) v(4'b0001, 0, 0, 4'b0001, 1, 8'h11, 0, 0, 0);
        v(4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        v(4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        run_vecs("single");

        // D: requester 1 drops after 2 beats; next grant passes to 3.
        v(4'b1010, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        for (int k = 0; k < 2; k++) v(4'b1010, 0, 0, 4'b0010, 1, 8'h22, 0, 0, 0);
        v(4'b1000, 0, 0, 4'b0000, 0, 8'h22, 0, 0, 0);
        v(4'b1010, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        for (int k = 0; k < 4; k++) v(4'b1010, 0, 0, 4'b1000, 1, 8'h44, 0, 0, 0);
        v(4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        run_vecs("drop");

        // B: all requesting; scoreboard of expected beats in order 0,1,2,3,0.
        for (int bi = 0; bi < 5; bi++) begin
            for (int k = 0; k < 4; k++) begin
                b.gnt  = 4'(1 << (bi % 4));
                b.data = data_of(bi % 4);
                sb.push_back(b);
            end
        end
        for (int k = 0; k < 25; k++) begin
            req       = 4'b1111;
            fifo_full = 1'b0;
            clr_req   = 1'b0;
            #1;
            chk($sformatf("rr[%0d].winc", k), 32'(fifo_winc), 32'((k % 5) != 0));
            if (fifo_winc) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rr[%0d].extra_beat: got beat expected none", k);
                end else begin
                    b = sb.pop_front();
                    chk($sformatf("rr[%0d].gnt", k), 32'(gnt), 32'(b.gnt));
                    chk($sformatf("rr[%0d].wdata", k), 32'(fifo_wdata), 32'(b.data));
                end
            end
            @(negedge clk);
        end
        chk("rr.remaining", 32'(sb.size()), 32'd0);

        // C: requester 2 stalled by fifo_full for 3 cycles after beat 2.
        v(4'b0100, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        for (int k = 0; k < 2; k++) v(4'b0100, 0, 0, 4'b0100, 1, 8'h33, 0, 0, 0);
        for (int k = 0; k < 3; k++) v(4'b0100, 1, 0, 4'b0000, 0, 8'h33, 0, 0, 0);
        for (int k = 0; k < 2; k++) v(4'b0100, 0, 0, 4'b0100, 1, 8'h33, 0, 0, 0);
        v(4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        run_vecs("full");

        // E: clear requested on beat 2; clr_req during DONE is ignored;
        //    arbitration then restarts at requester 0.
        v(4'b1111, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        v(4'b1111, 0, 0, 4'b1000, 1, 8'h44, 0, 0, 0);
        v(4'b1111, 0, 1, 4'b1000, 1, 8'h44, 0, 0, 0);
        v(4'b1111, 0, 0, 4'b0000, 0, 8'h44, 0, 1, 0);
        v(4'b1111, 0, 0, 4'b0000, 0, 8'h00, 0, 1, 0);
        v(4'b1111, 0, 0, 4'b0000, 0, 8'h00, 1, 1, 0);
        v(4'b1111, 0, 0, 4'b0000, 0, 8'h00, 1, 1, 0);
        v(4'b1111, 0, 1, 4'b0000, 0, 8'h00, 0, 1, 1);
        v(4'b1111, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        v(4'b1111, 0, 0, 4'b0001, 1, 8'h11, 0, 0, 0);
        v(4'b0000, 0, 0, 4'b0000, 0, 8'h11, 0, 0, 0);
        v(4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        run_vecs("clear");

        // F: reset asserted in the middle of a clear.
        v(4'b0000, 0, 1, 4'b0000, 0, 8'h00, 0, 0, 0);
        v(4'b0000, 0, 0, 4'b0000, 0, 8'h00, 1, 1, 0);
        run_vecs("rstclr");
        #1;
        chk("rstclr.wclr_before", 32'(fifo_wclr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstclr.wclr_async", 32'(fifo_wclr), 32'd0);
        chk("rstclr.busy_async", 32'(clr_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("rstclr.post[%0d].done", k), 32'(clr_done), 32'd0);
            chk($sformatf("rstclr.post[%0d].wclr", k), 32'(fifo_wclr), 32'd0);
            chk($sformatf("rstclr.post[%0d].busy", k), 32'(clr_busy), 32'd0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing a single FIFO write port (afifo write side) between N_REQ requesters in the write clock domain.
- Grants bursts of up to MAX_BURST beats per requester and throttles on FIFO full.
- Sequences a write-side clear: stops granting, drives the FIFO clear for CLR_CYCLES cycles, then reports done.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, data width per requester and FIFO write data width
MAX_BURST, 4, maximum beats accepted per grant (1..15)
CLR_CYCLES, 2, cycles fifo_wclr is held high during a clear (1..15)

Ports:
clk  in  1  write-domain clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester write request (level, held until accepted)
req_data  in  N_REQ*DATA_W  per-requester data; requester i occupies bits [i*DATA_W +: DATA_W]
gnt  out  N_REQ  one-hot accept; beat from requester i is taken in a cycle where gnt[i]=1
fifo_full  in  1  FIFO write-side full flag
fifo_winc  out  1  FIFO write increment
fifo_wdata  out  DATA_W  FIFO write data
fifo_wclr  out  1  FIFO write-side synchronous clear
clr_req  in  1  single-cycle clear request pulse
clr_busy  out  1  clear sequence in progress
clr_done  out  1  single-cycle pulse at the end of a clear

Behaviour:
- Reset (async, rst_n=0): state=IDLE, owner=0, last=N_REQ-1, beat_cnt=0, clr_pend=0, clr_cnt=0. All outputs are 0: gnt, fifo_winc, fifo_wdata, fifo_wclr, clr_busy, clr_done. Reset mid-burst or mid-clear aborts immediately.
- State register: IDLE, GRANT, CLEAR, DONE.
- clr_pend is set on clr_req in any state except CLEAR/DONE. It is cleared on entry to CLEAR. A clr_req arriving during CLEAR/DONE is ignored.
- IDLE:
  - If clr_pend=1 (or clr_req=1 this cycle), go to CLEAR.
  - Else, if any req is high, set owner = first index with req high, searching from (last+1) mod N_REQ upward with wraparound. Set beat_cnt=0 and go to GRANT.
  - Else stay in IDLE.
  - No beats are accepted in IDLE, giving a one-cycle arbitration bubble per grant.
- GRANT:
  - accept = req[owner] & ~fifo_full & ~clr_pend. accept is combinational from registered state.
  - gnt = accept ? onehot(owner) : 0.
  - fifo_winc = accept.
  - fifo_wdata = owner's slice of req_data, driven whenever in GRANT; 0 otherwise.
  - On accept, beat_cnt increments.
  - Return to IDLE and set last=owner when any of these hold:
    - accept and beat_cnt+1==MAX_BURST;
    - req[owner]=0;
    - clr_pend=1.
  - If fifo_full=1, hold GRANT; the beat count is unchanged and no timeout applies.
- CLEAR:
  - fifo_wclr=1 for exactly CLR_CYCLES consecutive cycles, counted by clr_cnt.
  - Then go to DONE.
  - No grants in CLEAR.
- DONE:
  - clr_done=1 for one cycle, fifo_wclr=0, then go to IDLE.
  - last resets to N_REQ-1, so arbitration restarts at requester 0.
- clr_busy=1 while clr_pend=1 or state is CLEAR or DONE.
- Counter widths: beat_cnt and clr_cnt are 4 bits; owner and last are clog2(N_REQ) bits, minimum 1.
- Wraparound: the search from last=N_REQ-1 starts at index 0.
- Simultaneous clr_req and a pending beat in GRANT: that cycle's beat is blocked (clr_pend takes effect combinationally from the cycle after clr_req). The beat in the clr_req cycle itself completes if accept holds.
- Invariants:
  - gnt is at most one-hot.
  - fifo_winc=1 implies fifo_full=0 in the same cycle.
  - fifo_winc and fifo_wclr are never high together.

Test Plan:
- Reset, then req=4'b0001, fifo_full=0, MAX_BURST=4 -> IDLE 1 cycle; gnt=0001 and fifo_winc=1 for 4 cycles with fifo_wdata=req_data[7:0]; 1 bubble; then 4 more beats.
- req=4'b1111 held, distinct data per requester -> grant order 0,1,2,3,0; each burst is 4 beats separated by one idle cycle; fifo_wdata matches the owner each beat.
- Requester 2 granted; fifo_full=1 for 3 cycles after beat 2 -> gnt=0 and fifo_winc=0 for 3 cycles; beats 3-4 then resume; burst total is still 4.
- req[1] drops after 2 beats while req=4'b1010 -> owner returns to IDLE; next grant goes to requester 3, not 1.
- clr_req pulse mid-burst (beat 2 of 4) -> that beat completes; no further gnt; clr_busy=1; fifo_wclr=1 for 2 cycles; clr_done pulse; next grant starts at requester 0.
- rst_n asserted during CLEAR -> fifo_wclr and clr_busy drop to 0 immediately; after release, state is IDLE with no clr_done pulse.
